// File: rtl/kernel_bank.sv
// Run-time programmable bank of KxK signed kernels. The active kernel is reloaded only at frame_start_in.
// Optional KERNEL_GAIN_CHECK_EN: flags committed kernels whose tap sum differs from (1 << shift).
module kernel_bank #(
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 4,
  parameter int COEFF_WIDTH = 8
) (
  input  logic                                                          clk_in,
  input  logic                                                          rst_in,
  input  logic                                                          frame_start_in,
  input  logic                                                          sel_valid_in,
  input  logic [$clog2(NUM_KERNELS)-1:0]                                sel_in,
  input  logic                                                          wr_valid_in,
  input  logic [$clog2(NUM_KERNELS)-1:0]                                wr_kernel_in,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE+1)-1:0]                  wr_index_in,
  input  logic [COEFF_WIDTH-1:0]                                        wr_data_in,
  output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][COEFF_WIDTH-1:0] coeffs_out,
  output logic [7:0]                                                    shift_out,
  output logic [$clog2(NUM_KERNELS)-1:0]                                active_sel_out,
  output logic                                                          pending_out,
  output logic                                                          update_out,
  output logic                                                          err_out,
  output logic                                                          gain_err_out
);

  localparam int K     = KERNEL_SIZE;
  localparam int KK    = K * K;
  localparam int SEL_W = $clog2(NUM_KERNELS);
  localparam int IDX_W = $clog2(KK + 1);

  typedef enum logic {IDLE, PENDING} sel_state_t;

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Power-on contents: bank 0 identity, bank 1 binomial Gaussian, the rest zero.
  function automatic logic signed [COEFF_WIDTH-1:0] init_tap(input int k, input int t);
    int v;
    v = 0;
    if (k == 0)      v = (t == KK / 2) ? 1 : 0;
    else if (k == 1) v = binom(K - 1, t / K) * binom(K - 1, t % K);
    return COEFF_WIDTH'(v);
  endfunction

  function automatic logic [7:0] init_shift(input int k);
    return (k == 1) ? 8'(2 * (K - 1)) : 8'd0;
  endfunction

  logic signed [COEFF_WIDTH-1:0] bank_taps [NUM_KERNELS][KK];
  logic [7:0]                    bank_shift [NUM_KERNELS];
  logic signed [COEFF_WIDTH-1:0] active_taps_reg [KK];
  logic [7:0]                    shift_reg;
  logic [SEL_W-1:0]              active_sel_reg;
  logic [SEL_W-1:0]              pending_sel_reg;
  sel_state_t                    state_reg;
  logic                          update_reg;
  logic                          err_reg;

  logic             sel_in_range, sel_ok, sel_bad;
  logic             wr_in_range, wr_ok, wr_bad;
  logic [SEL_W-1:0] tgt;
  logic [7:0]       wr_shift;

  assign sel_in_range = ({1'b0, sel_in} < (SEL_W + 1)'(NUM_KERNELS));
  assign sel_ok       = sel_valid_in && sel_in_range;
  assign sel_bad      = sel_valid_in && !sel_in_range;
  assign wr_in_range  = ({1'b0, wr_kernel_in} < (SEL_W + 1)'(NUM_KERNELS)) &&
                        (wr_index_in <= IDX_W'(KK));
  assign wr_ok        = wr_valid_in && wr_in_range;
  assign wr_bad       = wr_valid_in && !wr_in_range;

  // A selection arriving with the frame pulse overrides any older pending request.
  assign tgt = sel_ok                 ? sel_in :
               (state_reg == PENDING) ? pending_sel_reg : active_sel_reg;

  generate
    if (COEFF_WIDTH >= 8) begin : g_shift_wide
      assign wr_shift = wr_data_in[7:0];
    end else begin : g_shift_narrow
      assign wr_shift = {{(8 - COEFF_WIDTH){1'b0}}, wr_data_in};
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        for (int t = 0; t < KK; t++) bank_taps[k][t] <= init_tap(k, t);
        bank_shift[k] <= init_shift(k);
      end
      for (int t = 0; t < KK; t++) active_taps_reg[t] <= init_tap(1, t);
      shift_reg       <= init_shift(1);
      active_sel_reg  <= SEL_W'(1);
      pending_sel_reg <= '0;
      state_reg       <= IDLE;
      update_reg      <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      update_reg <= frame_start_in;
      err_reg    <= sel_bad || wr_bad;
      if (wr_ok) begin
        if (wr_index_in == IDX_W'(KK)) bank_shift[wr_kernel_in] <= wr_shift;
        else                           bank_taps[wr_kernel_in][wr_index_in] <= wr_data_in;
      end
      // Non-blocking reads here see the bank before any same-cycle write.
      if (frame_start_in) begin
        for (int t = 0; t < KK; t++) active_taps_reg[t] <= bank_taps[tgt][t];
        shift_reg      <= bank_shift[tgt];
        active_sel_reg <= tgt;
        state_reg      <= IDLE;
      end else if (sel_ok) begin
        pending_sel_reg <= sel_in;
        state_reg       <= PENDING;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KK; gi++) begin : g_out
      assign coeffs_out[gi / K][gi % K] = active_taps_reg[gi];
    end
  endgenerate

  assign shift_out      = shift_reg;
  assign active_sel_out = active_sel_reg;
  assign pending_out    = (state_reg == PENDING);
  assign update_out     = update_reg;
  assign err_out        = err_reg;

`ifdef KERNEL_GAIN_CHECK_EN
  localparam int SW = COEFF_WIDTH + 2 * $clog2(K) + 1;

  logic signed [SW-1:0] gain_sum;
  logic [SW:0]          gain_target;
  logic                 gain_mismatch;
  logic                 gain_err_reg;

  always_comb begin
    gain_sum = '0;
    for (int t = 0; t < KK; t++) gain_sum = gain_sum + SW'(bank_taps[tgt][t]);
  end

  // Target is one bit wider so 1 << (SW-1) is not read back as negative.
  assign gain_target   = (SW + 1)'(1) << bank_shift[tgt];
  assign gain_mismatch = (bank_shift[tgt] >= 8'(SW)) ||
                         ({gain_sum[SW-1], gain_sum} != gain_target);

  always_ff @(posedge clk_in) begin
    if (rst_in)              gain_err_reg <= 1'b0;
    else if (frame_start_in) gain_err_reg <= gain_mismatch;
  end

  assign gain_err_out = gain_err_reg;
`else
  assign gain_err_out = 1'b0;
`endif

endmodule
